// File: rtl/cmem_pipe.sv
// cmem_pipe: pipelined coefficient memory with separate read and write ports.
//
// DEPTH = 2**ADDR_W words of DATA_W bits. Inputs are registered (stage 0); the array
// write and array read happen one edge later (stage 1). A read request sampled at
// edge N produces q/q_valid after edge N+1. After reset, a hardware sweep writes
// INIT_VAL to every word before ready rises, so consumers never see X contents.
//
// Optional feature: define CMEM_PARITY_EN to store one even-parity bit per word.
// par_inj flips the stored parity bit on a write, and perr flags a parity mismatch on
// the read it belongs to. Without the macro, par_inj is ignored and perr is always 0.
//
// Ports:
//   clk      clock, all state updates on posedge
//   rst      asynchronous active-high reset
//   cen_n    chip enable (active low), gates both ports
//   ren_n    read enable (active low)
//   wen_n    write enable (active low)
//   raddr    read address
//   caddr    write address
//   d        write data
//   par_inj  parity-error inject on write (CMEM_PARITY_EN only)
//   ready    high once the init sweep has finished; requests accepted only then
//   q        read data, holds its value between reads
//   q_valid  one-cycle pulse qualifying q
//   perr     parity error, aligned with q_valid
module cmem_pipe #(
    parameter int unsigned        DATA_W   = 20,
    parameter int unsigned        ADDR_W   = 8,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen_n,
    input  logic              ren_n,
    input  logic              wen_n,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [ADDR_W-1:0] caddr,
    input  logic [DATA_W-1:0] d,
    input  logic              par_inj,
    output logic              ready,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              perr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef CMEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    localparam logic [0:0] StInit = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    // Control state
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;

    // Stage 0: registered request
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Stage 1: read output
    logic [DATA_W-1:0] q_q, q_d;
    logic              q_valid_q, q_valid_d;
    logic              perr_q, perr_d;

    // Array and its single write port (shared by the sweep and normal writes)
    logic [MEM_W-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  init_word;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
    logic              fwd;

`ifdef CMEM_PARITY_EN
    logic pinj_q, pinj_d;

    assign init_word = {^INIT_VAL, INIT_VAL};
    // par_inj deliberately corrupts the stored parity so the reader flags it
    assign wr_word   = {^data_q ^ pinj_q, data_q};
    assign pinj_d    = par_inj;
`else
    logic unused_par_inj;

    assign unused_par_inj = par_inj;
    assign init_word      = INIT_VAL;
    assign wr_word        = data_q;
`endif

    // Init sweep FSM: one word per cycle, RUN entered on the edge writing the last word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        if (state_q == StInit) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = StRun;
                ready_d = 1'b1;
            end
        end
    end

    // Stage 0 capture; requests are dropped while not ready
    always_comb begin
        rd_d    = ready_q & ~cen_n & ~ren_n;
        wr_d    = ready_q & ~cen_n & ~wen_n;
        raddr_d = raddr;
        caddr_d = caddr;
        data_d  = d;
    end

    // Write port: the sweep owns the array until RUN
    always_comb begin
        if (state_q == StInit) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = init_word;
        end else begin
            mem_we    = wr_q;
            mem_waddr = caddr_q;
            mem_wdata = wr_word;
        end
    end

    // Read port with write-first forwarding on an address collision
    always_comb begin
        fwd       = wr_q & (raddr_q == caddr_q);
        rd_word   = fwd ? wr_word : mem[raddr_q];
        q_d       = q_q;
        q_valid_d = rd_q;
        perr_d    = 1'b0;
        if (rd_q) begin
            q_d = rd_word[DATA_W-1:0];
`ifdef CMEM_PARITY_EN
            perr_d = ^rd_word[DATA_W-1:0] ^ rd_word[DATA_W];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            raddr_q   <= '0;
            caddr_q   <= '0;
            data_q    <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            raddr_q   <= raddr_d;
            caddr_q   <= caddr_d;
            data_q    <= data_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            perr_q    <= perr_d;
        end
    end

`ifdef CMEM_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pinj_q <= 1'b0;
        end else begin
            pinj_q <= pinj_d;
        end
    end
`endif

    // Array contents are not reset; the sweep overwrites them
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign ready   = ready_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign perr    = perr_q;

endmodule

// File: doc/cmem_pipe.md
Name: cmem_pipe

Overview:
- Parametrised successor to the single-port coefficient memory.
- Stores DEPTH words of DATA_W bits with separate read and write ports, active in the same cycle.
- Registered inputs, fixed 2-edge read latency, read-during-write forwarding.
- Post-reset hardware init sweep, so downstream MAC/accumulate logic never reads X or stale pre-computed sums.

Parameters:
DATA_W, 20, word width in bits
ADDR_W, 8, address width in bits; DEPTH = 2**ADDR_W
INIT_VAL, 0, value written to every word during the init sweep (DATA_W bits)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
cen_n  in  1  chip enable, active low; gates both ports
ren_n  in  1  read enable, active low
wen_n  in  1  write enable, active low
raddr  in  ADDR_W  read address
caddr  in  ADDR_W  write address for pre-computed sums
d  in  DATA_W  write data
par_inj  in  1  parity-error inject on write; ignored unless CMEM_PARITY_EN
ready  out  1  high when init is complete and requests are accepted
q  out  DATA_W  read data
q_valid  out  1  one-cycle pulse qualifying q
perr  out  1  parity error flag, aligned with q_valid

Behaviour:
Reset (rst high, asynchronous):
- FSM to INIT; sweep counter = 0.
- ready = 0, q = 0, q_valid = 0, perr = 0.
- All input pipeline registers cleared, with both enables inactive.
- Array contents are not reset directly; the sweep overwrites them.

FSM:
- INIT: each cycle write INIT_VAL to mem[cnt], cnt++.
- INIT -> RUN on the edge that writes address DEPTH-1.
- ready = 1 only in RUN, registered, so it rises on that same edge.
- ready is low for exactly DEPTH cycles after rst deasserts.
- RUN stays in RUN until rst.

Stage 0 (edge N): sample inputs into registers.
- rd_r = ready & ~cen_n & ~ren_n
- wr_r = ready & ~cen_n & ~wen_n
- raddr_r, caddr_r, d_r
- Requests while ready = 0 are dropped; no queuing.

Stage 1 (edge N+1):
- If wr_r: mem[caddr_r] <= d_r.
- If rd_r: q <= mem[raddr_r] and q_valid <= 1; otherwise q_valid <= 0 and q holds its previous value.
- Read latency: q/q_valid valid after edge N+1 for a request sampled at edge N.
- Sustained rate: one read plus one write per cycle.

Collision (rd_r & wr_r & raddr_r == caddr_r):
- Write-first: q <= d_r (forwarded), not the old array value.

Back-to-back:
- A write sampled at N and a read of the same address sampled at N+1 returns the new data with no stall.

Reset mid-operation:
- Any in-flight stage-0/1 operation is discarded; its write is not committed.
- Sweep restarts at address 0.

perr is 0 whenever q_valid is 0.

Optional Feature:
Macro CMEM_PARITY_EN.
- Defined:
  - Array width is DATA_W+1; stored bit = ^d_r ^ par_inj_r; the sweep stores the correct parity of INIT_VAL.
  - On a read, perr <= q_valid-qualified mismatch of the recomputed vs stored parity.
  - A forwarded read uses the forwarded parity bit.
  - q data is unaffected by a parity error.
- Not defined: array width is DATA_W, par_inj is ignored, perr is constant 0.

Test Plan:
1. Init sweep: rst high 3 cycles, release. Check ready low for exactly 256 cycles, then high. Read 0x00 and 0xFF: q = 0x00000 with q_valid 2 edges after each request.
2. Write/read: write d = 0x12345 to caddr 0x10, then read raddr 0x10 on the next cycle. Check q = 0x12345, q_valid high for exactly one cycle, perr = 0.
3. Collision: in one cycle write 0xABCDE to 0x20 and read 0x20 (old value 0x00001). Check q = 0xABCDE. A simultaneous read of 0x21 during a write to 0x20 returns mem[0x21].
4. Requests during init: assert cen_n = 0, wen_n = 0, d = 0x11111, caddr = 0x05 while ready = 0. After ready rises, read 0x05: q = 0x00000.
5. Reset mid-sweep: pulse rst at sweep count 100. Check ready stays low a full 256 further cycles. Check q_valid = 0 and q = 0 during reset.
6. Parity (CMEM_PARITY_EN): write 0x0F0F0 to 0x30 with par_inj = 1, then read 0x30. Check q = 0x0F0F0, q_valid = 1, perr = 1. A clean write to 0x31, then read, gives perr = 0. Without the macro, perr is always 0.
